// File: rtl/glitch_sweep_ctrl.sv
// Glitch sweep scheduler: steps the pulser over a delay x width grid.
// Optional arm timeout is built in with SWEEP_TRIGGER_TIMEOUT_EN.
module glitch_sweep_ctrl #(
  parameter int RESET_CYCLES   = 1000,
  parameter int SETTLE_CYCLES  = 5000,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [15:0] delay_start_i,
  input  logic [15:0] delay_step_i,
  input  logic [7:0]  delay_count_i,
  input  logic [7:0]  width_start_i,
  input  logic [7:0]  width_step_i,
  input  logic [7:0]  width_count_i,
  input  logic        trigger_i,
  input  logic        busy_i,
  output logic [15:0] delay_o,
  output logic [7:0]  width_o,
  output logic        pulse_en_o,
  output logic        target_reset_o,
  output logic        active_o,
  output logic        attempt_o,
  output logic        timeout_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    IDLE,
    RESET_TGT,
    SETTLE,
    ARM,
    FIRE,
    WAIT_START,
    WAIT_DONE,
    NEXT
  } state_t;

  localparam state_t FIRST = (RESET_CYCLES == 0) ? SETTLE : RESET_TGT;

  localparam logic [31:0] RST_LAST =
    (RESET_CYCLES > 0) ? 32'(RESET_CYCLES - 1) : 32'd0;
  localparam logic [31:0] SET_LAST =
    (SETTLE_CYCLES > 0) ? 32'(SETTLE_CYCLES - 1) : 32'd0;

  // busy must show up within 4 cycles of the fire cycle,
  // so WAIT_START lasts at most 3 cycles
  localparam logic [31:0] WS_LAST = 32'd2;

  localparam int M1 =
    (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int M2 =
    (M1 > TIMEOUT_CYCLES) ? M1 : TIMEOUT_CYCLES;
  localparam logic [31:0] CNT_MAX = 32'(M2);

`ifdef SWEEP_TRIGGER_TIMEOUT_EN
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES);
`endif

  state_t state;
  state_t state_nxt;

  logic [31:0] cnt;
  logic [15:0] d_step;
  logic [7:0]  d_cnt;
  logic [7:0]  d_idx;
  logic [7:0]  w_start;
  logic [7:0]  w_step;
  logic [7:0]  w_cnt;
  logic [7:0]  w_idx;

  logic w_last;
  logic d_last;
  logic last_pt;
  logic go;
  logic arm_expired;

  assign w_last  = (w_idx == w_cnt - 8'd1);
  assign d_last  = (d_idx == d_cnt - 8'd1);
  assign last_pt = w_last && d_last;
  assign go      = start_i && !abort_i;

`ifdef SWEEP_TRIGGER_TIMEOUT_EN
  assign arm_expired = (cnt == TO_LIM);
`else
  assign arm_expired = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state decode; abort pulls every busy state back to IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (go) state_nxt = FIRST;
      end
      RESET_TGT: begin
        if (cnt == RST_LAST) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (cnt == SET_LAST) state_nxt = ARM;
      end
      ARM: begin
        if (trigger_i) state_nxt = FIRE;
        else if (arm_expired) state_nxt = NEXT;
      end
      FIRE: begin
        state_nxt = WAIT_START;
      end
      WAIT_START: begin
        if (busy_i) state_nxt = WAIT_DONE;
        else if (cnt == WS_LAST) state_nxt = NEXT;
      end
      WAIT_DONE: begin
        if (!busy_i) state_nxt = NEXT;
      end
      NEXT: begin
        state_nxt = last_pt ? IDLE : FIRST;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_i && state != IDLE) state_nxt = IDLE;
  end

  // state outputs; active drops together with done
  always_comb begin
    target_reset_o = 1'b0;
    pulse_en_o     = 1'b0;
    attempt_o      = 1'b0;
    timeout_o      = 1'b0;
    done_o         = 1'b0;
    unique case (state)
      RESET_TGT: target_reset_o = 1'b1;
      FIRE:      pulse_en_o     = 1'b1;
      ARM: begin
        timeout_o = arm_expired && !trigger_i && !abort_i;
      end
      NEXT: begin
        attempt_o = !abort_i;
        done_o    = !abort_i && last_pt;
      end
      default: ;
    endcase
    active_o = (state != IDLE) && !done_o;
  end

  // per-state cycle counter, cleared on every state change
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 32'd0;
    end else if (state_nxt != state) begin
      cnt <= 32'd0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 32'd1;
    end
  end

  // shadow config and sweep point; held on abort
  always_ff @(posedge clk) begin
    if (rst) begin
      d_step  <= 16'd0;
      d_cnt   <= 8'd0;
      d_idx   <= 8'd0;
      w_start <= 8'd0;
      w_step  <= 8'd0;
      w_cnt   <= 8'd0;
      w_idx   <= 8'd0;
      delay_o <= 16'd0;
      width_o <= 8'd0;
    end else if (state == IDLE && go) begin
      d_step  <= delay_step_i;
      d_cnt   <= (delay_count_i == 8'd0) ? 8'd1 : delay_count_i;
      d_idx   <= 8'd0;
      w_start <= width_start_i;
      w_step  <= width_step_i;
      w_cnt   <= (width_count_i == 8'd0) ? 8'd1 : width_count_i;
      w_idx   <= 8'd0;
      delay_o <= delay_start_i;
      width_o <= width_start_i;
    end else if (state == NEXT && !abort_i) begin
      if (!w_last) begin
        w_idx   <= w_idx + 8'd1;
        width_o <= width_o + w_step;
      end else begin
        w_idx   <= 8'd0;
        width_o <= w_start;
        d_idx   <= d_idx + 8'd1;
        delay_o <= delay_o + d_step;
      end
    end
  end

endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// Directed bench for glitch_sweep_ctrl.
// Timeout section runs when SWEEP_TRIGGER_TIMEOUT_EN is defined.
module tb_glitch_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] delay_start;
  logic [15:0] delay_step;
  logic [7:0]  delay_count;
  logic [7:0]  width_start;
  logic [7:0]  width_step;
  logic [7:0]  width_count;
  logic        trigger;
  logic        busy;
  logic [15:0] delay;
  logic [7:0]  width;
  logic        pulse_en;
  logic        target_reset;
  logic        active;
  logic        attempt;
  logic        timeout;
  logic        done;

  glitch_sweep_ctrl #(
    .RESET_CYCLES  (4),
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .abort_i       (abort),
    .delay_start_i (delay_start),
    .delay_step_i  (delay_step),
    .delay_count_i (delay_count),
    .width_start_i (width_start),
    .width_step_i  (width_step),
    .width_count_i (width_count),
    .trigger_i     (trigger),
    .busy_i        (busy),
    .delay_o       (delay),
    .width_o       (width),
    .pulse_en_o    (pulse_en),
    .target_reset_o(target_reset),
    .active_o      (active),
    .attempt_o     (attempt),
    .timeout_o     (timeout),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int n_pulse = 0;
  int n_att = 0;
  int n_done = 0;
  int n_to = 0;
  int n_to_all = 0;
  int rise = 0;
  int last_fire = 0;
  int last_att = 0;
  int last_done = 0;
  int busy_len = 20;
  logic tr_q = 1'b0;
  logic [15:0] pd[$];
  logic [7:0]  pw[$];

  task automatic clear_log();
    n_pulse = 0;
    n_att = 0;
    n_done = 0;
    n_to = 0;
    pd.delete();
    pw.delete();
  endtask

  // event monitor: reset length, arm latency, pulse log
  initial begin
    forever begin
      @(negedge clk);
      if (target_reset && !tr_q) rise = cyc;
      if (!target_reset && tr_q)
        check("rst_len", cyc - rise, 4);
      tr_q = target_reset;
      if (pulse_en) begin
        n_pulse++;
        pd.push_back(delay);
        pw.push_back(width);
        last_fire = cyc;
        check("fire_lat", cyc - rise, 9);
      end
      if (attempt) begin
        n_att++;
        last_att = cyc;
      end
      if (done) begin
        n_done++;
        last_done = cyc;
        check("done_active", {31'd0, active}, 0);
      end
      if (timeout) begin
        n_to++;
        n_to_all++;
        check("to_lat", cyc - rise, 58);
      end
    end
  end

  // pulser model: busy for busy_len cycles after each fire
  initial begin
    busy = 1'b0;
    forever begin
      @(negedge clk);
      if (pulse_en && busy_len > 0) begin
        busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        busy = 1'b0;
      end
    end
  end

  task automatic set_cfg(logic [15:0] ds, logic [15:0] dt,
                         logic [7:0] dc, logic [7:0] ws,
                         logic [7:0] wt, logic [7:0] wc);
    delay_start = ds;
    delay_step  = dt;
    delay_count = dc;
    width_start = ws;
    width_step  = wt;
    width_count = wc;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    set_cfg(16'hDEAD, 16'h0BAD, 8'd9, 8'hEE, 8'h33, 8'd7);
  endtask

  task automatic wait_done(int max);
    int n0;
    int k;
    n0 = n_done;
    k = 0;
    while (n_done == n0 && k < max) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", n_done - n0, 1);
  endtask

  logic [15:0] exp_d[6];
  logic [7:0]  exp_w[6];
  logic [15:0] wrp_d[4];
  logic [7:0]  wrp_w[4];
  int k;

  initial begin
    exp_d = '{16'd100, 16'd100, 16'd100, 16'd110, 16'd110, 16'd110};
    exp_w = '{8'd5, 8'd6, 8'd7, 8'd5, 8'd6, 8'd7};
    wrp_d = '{16'hFFF0, 16'hFFF0, 16'h0010, 16'h0010};
    wrp_w = '{8'hFF, 8'h00, 8'hFF, 8'h00};

    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    trigger = 1'b1;
    set_cfg(16'd0, 16'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_delay", {16'd0, delay}, 0);
    check("rst_width", {24'd0, width}, 0);
    check("rst_ctl",
          {26'd0, pulse_en, target_reset, active,
           attempt, timeout, done}, 0);

    // basic sweep, config scrambled right after start
    clear_log();
    set_cfg(16'd100, 16'd10, 8'd2, 8'd5, 8'd1, 8'd3);
    pulse_start();
    wait_done(2000);
    check("sw_pulses", n_pulse, 6);
    check("sw_atts", n_att, 6);
    check("sw_dones", n_done, 1);
    for (int i = 0; i < 6; i++) begin
      if (i < pd.size()) begin
        check("sw_delay", {16'd0, pd[i]}, {16'd0, exp_d[i]});
        check("sw_width", {24'd0, pw[i]}, {24'd0, exp_w[i]});
      end
    end
    check("sw_idle_active", {31'd0, active}, 0);

    // wrap-around of both parameters
    repeat (5) @(negedge clk);
    clear_log();
    set_cfg(16'hFFF0, 16'h0020, 8'd2, 8'hFF, 8'd1, 8'd2);
    pulse_start();
    wait_done(2000);
    check("wr_pulses", n_pulse, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < pd.size()) begin
        check("wr_delay", {16'd0, pd[i]}, {16'd0, wrp_d[i]});
        check("wr_width", {24'd0, pw[i]}, {24'd0, wrp_w[i]});
      end
    end

    // abort in WAIT_DONE of the second attempt
    repeat (5) @(negedge clk);
    clear_log();
    set_cfg(16'd100, 16'd10, 8'd2, 8'd5, 8'd1, 8'd3);
    pulse_start();
    k = 0;
    while (n_pulse < 2 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("ab_reach", n_pulse, 2);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_active", {31'd0, active}, 0);
    check("ab_ctl", {30'd0, target_reset, pulse_en}, 0);
    check("ab_delay", {16'd0, delay}, 100);
    check("ab_width", {24'd0, width}, 6);
    repeat (30) @(negedge clk);
    check("ab_nodone", n_done, 0);
    check("ab_atts", n_att, 1);
    clear_log();
    set_cfg(16'd100, 16'd10, 8'd2, 8'd5, 8'd1, 8'd3);
    pulse_start();
    wait_done(2000);
    check("ab_re_pulses", n_pulse, 6);
    if (pd.size() > 0) begin
      check("ab_re_delay", {16'd0, pd[0]}, 100);
      check("ab_re_width", {24'd0, pw[0]}, 5);
    end

    // zero counts, pulser never reports busy
    repeat (5) @(negedge clk);
    clear_log();
    busy_len = 0;
    set_cfg(16'h1234, 16'd1, 8'd0, 8'h56, 8'd1, 8'd0);
    pulse_start();
    wait_done(500);
    check("z_pulses", n_pulse, 1);
    check("z_atts", n_att, 1);
    check("z_next_lat", last_att - last_fire, 4);
    check("z_done_cyc", last_done, last_att);
    if (pd.size() > 0) begin
      check("z_delay", {16'd0, pd[0]}, 32'h1234);
      check("z_width", {24'd0, pw[0]}, 32'h56);
    end

`ifdef SWEEP_TRIGGER_TIMEOUT_EN
    // trigger never arrives: each attempt ends on timeout
    repeat (5) @(negedge clk);
    clear_log();
    busy_len = 20;
    trigger = 1'b0;
    set_cfg(16'd200, 16'd7, 8'd1, 8'd9, 8'd3, 8'd2);
    pulse_start();
    k = 0;
    while (n_att < 1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("to_width_adv", {24'd0, width}, 12);
    wait_done(500);
    check("to_count", n_to, 2);
    check("to_pulses", n_pulse, 0);
    check("to_atts", n_att, 2);
    check("to_delay_end", {16'd0, delay}, 207);
`else
    check("to_never", n_to_all, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
